// File: rtl/operator_scheduler.sv
// operator_scheduler
//   Time-multiplexed phase sequencer for the FM matrix oscillator bank. A single
//   phase-accumulate datapath serves NUM_OPS operators. Each accepted sample_tick
//   commits the shadow increment/offset configuration. The block then issues
//   operators 0..NUM_OPS-1, one per enabled cycle. Each issue updates that
//   operator's phase and registers its wavetable address and interpolation fraction.
//
//   Ports
//     Clk, Reset_n        clock, asynchronous active-low reset
//     En                  global advance enable (low stalls the walk)
//     sample_tick         frame start request
//     cfg_we/sel/op/data  shadow config write (sel 0 = increment, 1 = offset)
//     fm_input            modulation for operator op_sel, used in its issue cycle
//     overrun_clr         clears the sticky overrun flag
//     op_sel, busy        operator being issued, frame in progress
//     out_valid, out_op   registered output qualifier and operator index
//     wavetable_addr      upper AW bits of (pre-update phase + offset)
//     interp              lower IW bits of (pre-update phase + offset)
//     frame_done          pulses with the last out_valid of a frame
//     overrun             sticky: tick seen while busy
//
//   Optional build macro KEY_SYNC_EN adds input key_sync[NUM_OPS-1:0].
//   Each set bit becomes a pending phase reset for its operator. The pending
//   resets are applied at the next frame commit.
module operator_scheduler #(
    parameter int  DW      = 32,
    parameter int  AW      = 12,
    parameter int  NUM_OPS = 4,
    localparam int IW      = DW - AW,
    localparam int OPW     = $clog2(NUM_OPS)
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               En,
    input  logic               sample_tick,
    input  logic               cfg_we,
    input  logic               cfg_sel,
    input  logic [OPW-1:0]     cfg_op,
    input  logic [DW-1:0]      cfg_data,
    input  logic [DW-1:0]      fm_input,
    input  logic               overrun_clr,
`ifdef KEY_SYNC_EN
    input  logic [NUM_OPS-1:0] key_sync,
`endif
    output logic [OPW-1:0]     op_sel,
    output logic               busy,
    output logic               out_valid,
    output logic [OPW-1:0]     out_op,
    output logic [AW-1:0]      wavetable_addr,
    output logic [IW-1:0]      interp,
    output logic               frame_done,
    output logic               overrun
);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e         state_q, state_d;
    logic [OPW-1:0] cnt_q, cnt_d;
    logic           issue, last, commit;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (commit) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (En) begin
                    if (last) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / decode ----------------
    always_comb begin
        busy   = (state_q == S_RUN);
        op_sel = cnt_q;
        issue  = busy && En;
        last   = (cnt_q == OPW'(NUM_OPS - 1));
        commit = !busy && sample_tick && En;
    end

    // ---------------- datapath ----------------
    logic [NUM_OPS-1:0][DW-1:0] phase_q,   phase_d;
    logic [NUM_OPS-1:0][DW-1:0] sh_inc_q,  sh_inc_d;
    logic [NUM_OPS-1:0][DW-1:0] sh_off_q,  sh_off_d;
    logic [NUM_OPS-1:0][DW-1:0] act_inc_q, act_inc_d;
    logic [NUM_OPS-1:0][DW-1:0] act_off_q, act_off_d;
    logic                       out_valid_q, out_valid_d;
    logic [OPW-1:0]             out_op_q,    out_op_d;
    logic [DW-1:0]              out_word_q,  out_word_d;
    logic                       frame_done_q, frame_done_d;
    logic                       overrun_q,   overrun_d;
    logic                       cfg_hit;

    // Extra bit so the bound check still works when NUM_OPS is a power of two.
    assign cfg_hit = cfg_we && ({1'b0, cfg_op} < (OPW + 1)'(NUM_OPS));

`ifdef KEY_SYNC_EN
    logic [NUM_OPS-1:0] pending_q, pending_d;

    // A key_sync bit that arrives in the commit cycle lands after the clear.
    // That bit therefore stays pending for the following frame.
    always_comb begin
        pending_d = (commit ? '0 : pending_q) | key_sync;
    end
`endif

    always_comb begin
        phase_d      = phase_q;
        sh_inc_d     = sh_inc_q;
        sh_off_d     = sh_off_q;
        act_inc_d    = act_inc_q;
        act_off_d    = act_off_q;
        out_valid_d  = issue;
        out_op_d     = out_op_q;
        out_word_d   = out_word_q;
        frame_done_d = issue && last;

        if (cfg_hit) begin
            if (cfg_sel) sh_off_d[cfg_op] = cfg_data;
            else         sh_inc_d[cfg_op] = cfg_data;
        end

        // Commit samples the registered shadow. A write in the same cycle
        // therefore only reaches the next frame.
        if (commit) begin
            act_inc_d = sh_inc_q;
            act_off_d = sh_off_q;
`ifdef KEY_SYNC_EN
            for (int i = 0; i < NUM_OPS; i++)
                if (pending_q[i]) phase_d[i] = '0;
`endif
        end

        // The output uses the pre-update phase. The accumulator advances
        // in the same cycle.
        if (issue) begin
            phase_d[cnt_q] = phase_q[cnt_q] + act_inc_q[cnt_q] + fm_input;
            out_op_d       = cnt_q;
            out_word_d     = phase_q[cnt_q] + act_off_q[cnt_q];
        end

        // A new overrun event takes priority over a clear in the same cycle.
        if (sample_tick && busy) overrun_d = 1'b1;
        else if (overrun_clr)    overrun_d = 1'b0;
        else                     overrun_d = overrun_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            phase_q      <= '0;
            sh_inc_q     <= '0;
            sh_off_q     <= '0;
            act_inc_q    <= '0;
            act_off_q    <= '0;
            out_valid_q  <= 1'b0;
            out_op_q     <= '0;
            out_word_q   <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef KEY_SYNC_EN
            pending_q    <= '0;
`endif
        end else begin
            phase_q      <= phase_d;
            sh_inc_q     <= sh_inc_d;
            sh_off_q     <= sh_off_d;
            act_inc_q    <= act_inc_d;
            act_off_q    <= act_off_d;
            out_valid_q  <= out_valid_d;
            out_op_q     <= out_op_d;
            out_word_q   <= out_word_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
`ifdef KEY_SYNC_EN
            pending_q    <= pending_d;
`endif
        end
    end

    assign out_valid      = out_valid_q;
    assign out_op         = out_op_q;
    assign wavetable_addr = out_word_q[DW-1:IW];
    assign interp         = out_word_q[IW-1:0];
    assign frame_done     = frame_done_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_operator_scheduler.sv
module tb_operator_scheduler;
    localparam int DW = 32, AW = 12, NUM_OPS = 4, IW = DW - AW, OPW = 2;

    logic              Clk = 1'b0, Reset_n = 1'b0, En = 1'b0, sample_tick = 1'b0;
    logic              cfg_we = 1'b0, cfg_sel = 1'b0, overrun_clr = 1'b0;
    logic [OPW-1:0]    cfg_op = '0;
    logic [DW-1:0]     cfg_data = '0, fm_input = '0;
    logic [NUM_OPS-1:0] key_sync = '0;
    logic [OPW-1:0]    op_sel, out_op;
    logic              busy, out_valid, frame_done, overrun;
    logic [AW-1:0]     wavetable_addr;
    logic [IW-1:0]     interp;

    operator_scheduler #(.DW(DW), .AW(AW), .NUM_OPS(NUM_OPS)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .En(En), .sample_tick(sample_tick),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_op(cfg_op), .cfg_data(cfg_data),
        .fm_input(fm_input), .overrun_clr(overrun_clr),
`ifdef KEY_SYNC_EN
        .key_sync(key_sync),
`endif
        .op_sel(op_sel), .busy(busy), .out_valid(out_valid), .out_op(out_op),
        .wavetable_addr(wavetable_addr), .interp(interp),
        .frame_done(frame_done), .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [OPW-1:0] op;
        logic [DW-1:0]  word;
        logic           done;
    } exp_t;

    typedef struct {
        bit             rst;
        bit             wr;
        logic [DW-1:0]  inc0, off1, fm2;
        logic [AW-1:0]  e0, e1, e2;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t tbl[7];
    int   n_chk = 0, n_pass = 0;
    int   done_cyc = 0, tick_cyc = 0;

    logic [DW-1:0]      m_phase[NUM_OPS], m_inc[NUM_OPS], m_off[NUM_OPS];
    logic [DW-1:0]      m_sh_inc[NUM_OPS], m_sh_off[NUM_OPS];
    logic [NUM_OPS-1:0] m_pend;
    logic [AW-1:0]      cap_addr[NUM_OPS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Scoreboard consumer: every out_valid must match the oldest expected issue.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_out: out_valid with op %0d, nothing expected", out_op);
                end else begin
                    mon_e = sbq.pop_front();
                    check("out_op", 64'(out_op), 64'(mon_e.op));
                    check("addr", 64'(wavetable_addr), 64'(mon_e.word[DW-1:IW]));
                    check("interp", 64'(interp), 64'(mon_e.word[IW-1:0]));
                    check("frame_done", 64'(frame_done), 64'(mon_e.done));
                    cap_addr[out_op] = wavetable_addr;
                    if (frame_done) done_cyc = cyc;
                end
            end else if (frame_done) begin
                n_chk++;
                $display("FAIL done_without_valid: frame_done=1 with out_valid=0");
            end
        end
    end

    task automatic m_reset();
        for (int i = 0; i < NUM_OPS; i++) begin
            m_phase[i] = '0; m_inc[i] = '0; m_off[i] = '0;
            m_sh_inc[i] = '0; m_sh_off[i] = '0; cap_addr[i] = '0;
        end
        m_pend = '0;
        sbq.delete();
    endtask

    task automatic cfg_set(input logic sel, input logic [OPW-1:0] op, input logic [DW-1:0] d);
        cfg_we = 1'b1; cfg_sel = sel; cfg_op = op; cfg_data = d;
        if (sel) m_sh_off[op] = d;
        else     m_sh_inc[op] = d;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        m_reset();
        @(posedge Clk); #1;
        Reset_n = 1'b1;
    endtask

    // One frame. stall_k/otick_k/wmid_k select the issue index that gets a stall,
    // a busy tick or a mid-frame offset[3] write. -1 disables each option.
    // wcommit writes inc[3] in the commit cycle.
    task automatic run_frame(input logic [DW-1:0] fm2, input int stall_k, input int nstall,
                             input int otick_k, input bit wcommit, input int wmid_k);
        logic [DW-1:0] fm;
        exp_t e;
        sample_tick = 1'b1; En = 1'b1;
        for (int i = 0; i < NUM_OPS; i++) begin
            m_inc[i] = m_sh_inc[i];
            m_off[i] = m_sh_off[i];
            if (m_pend[i]) m_phase[i] = '0;
        end
        m_pend = '0;
        if (wcommit) cfg_set(1'b0, 2'd3, 32'h0040_0000);
        @(posedge Clk); #1;
        sample_tick = 1'b0; cfg_we = 1'b0; tick_cyc = cyc;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (k == stall_k) begin
                En = 1'b0;
                repeat (nstall) begin @(posedge Clk); #1; end
                En = 1'b1;
            end
            check("op_sel", 64'(op_sel), 64'(k));
            check("busy", 64'(busy), 64'd1);
            fm = (k == 2) ? fm2 : '0;
            fm_input = fm;
            if (k == otick_k) sample_tick = 1'b1;
            if (k == wmid_k) cfg_set(1'b1, 2'd3, 32'h1000_0000);
            e.op = OPW'(k);
            e.word = m_phase[k] + m_off[k];
            e.done = (k == NUM_OPS - 1);
            sbq.push_back(e);
            m_phase[k] = m_phase[k] + m_inc[k] + fm;
            @(posedge Clk); #1;
            sample_tick = 1'b0; cfg_we = 1'b0; fm_input = '0;
            if (k == otick_k) check("overrun_set", 64'(overrun), 64'd1);
        end
        check("busy_end", 64'(busy), 64'd0);
        @(negedge Clk); #1;
        check("sb_drained", 64'(sbq.size()), 64'd0);
        check("done_latency", 64'(done_cyc - tick_cyc),
              64'(NUM_OPS + ((stall_k >= 0) ? nstall : 0)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         12'h000, 12'h000, 12'h000};
        tbl[1] = '{1'b0, 1'b1, 32'h0010_0000, 32'h8000_0000, 32'h0020_0000, 12'h000, 12'h800, 12'h000};
        tbl[2] = '{1'b0, 1'b0, 32'h0,         32'h0,         32'h0020_0000, 12'h001, 12'h800, 12'h002};
        tbl[3] = '{1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         12'h002, 12'h800, 12'h004};
        tbl[4] = '{1'b1, 1'b1, 32'hFFF0_0000, 32'h0,         32'h0,         12'h000, 12'h000, 12'h000};
        tbl[5] = '{1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         12'hFFF, 12'h000, 12'h000};
        tbl[6] = '{1'b0, 1'b0, 32'h0,         32'h0,         32'h0,         12'hFFE, 12'h000, 12'h000};

        m_reset();
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_op_sel", 64'(op_sel), 64'd0);
        check("rst_addr", 64'(wavetable_addr), 64'd0);
        check("rst_interp", 64'(interp), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;

        // Table-driven frames: accumulate, offset, FM, wrap.
        for (int r = 0; r < 7; r++) begin
            if (tbl[r].rst) do_reset();
            if (tbl[r].wr) begin
                cfg_set(1'b0, 2'd0, tbl[r].inc0); @(posedge Clk); #1;
                cfg_set(1'b1, 2'd1, tbl[r].off1); @(posedge Clk); #1;
                cfg_set(1'b0, 2'd2, 32'h0);       @(posedge Clk); #1;
                cfg_we = 1'b0;
            end
            run_frame(tbl[r].fm2, -1, 0, -1, 1'b0, -1);
            check($sformatf("tbl%0d_op0", r), 64'(cap_addr[0]), 64'(tbl[r].e0));
            check($sformatf("tbl%0d_op1", r), 64'(cap_addr[1]), 64'(tbl[r].e1));
            check($sformatf("tbl%0d_op2", r), 64'(cap_addr[2]), 64'(tbl[r].e2));
        end

        // Stall of 3 cycles before op2: frame_done arrives 3 cycles later.
        run_frame(32'h0, 2, 3, -1, 1'b0, -1);

        // Tick while busy sets overrun and leaves the frame alone; then clear.
        run_frame(32'h0, -1, 0, 1, 1'b0, -1);
        check("overrun_sticky", 64'(overrun), 64'd1);
        overrun_clr = 1'b1; @(posedge Clk); #1; overrun_clr = 1'b0;
        check("overrun_cleared", 64'(overrun), 64'd0);

        // Tick during the last issue together with clear: the set wins.
        overrun_clr = 1'b1;
        run_frame(32'h0, -1, 0, 3, 1'b0, -1);
        overrun_clr = 1'b0;
        check("overrun_set_wins", 64'(overrun), 64'd1);
        overrun_clr = 1'b1; @(posedge Clk); #1; overrun_clr = 1'b0;

        // Tick with En low in IDLE is dropped.
        En = 1'b0; sample_tick = 1'b1; @(posedge Clk); #1; sample_tick = 1'b0;
        check("tick_en_low_busy", 64'(busy), 64'd0);
        check("tick_en_low_overrun", 64'(overrun), 64'd0);
        En = 1'b1;

        // Shadow commit: inc[3] written at commit, offset[3] written mid-frame.
        run_frame(32'h0, -1, 0, -1, 1'b1, 1);
        check("shadow_a_op3", 64'(cap_addr[3]), 64'h000);
        run_frame(32'h0, -1, 0, -1, 1'b0, -1);
        check("shadow_b_op3", 64'(cap_addr[3]), 64'h100);
        run_frame(32'h0, -1, 0, -1, 1'b0, -1);
        check("shadow_c_op3", 64'(cap_addr[3]), 64'h104);

`ifdef KEY_SYNC_EN
        key_sync = 4'b0001; @(posedge Clk); #1; key_sync = '0;
        m_pend = 4'b0001;
        run_frame(32'h0, -1, 0, -1, 1'b0, -1);
        check("key_sync_op0", 64'(cap_addr[0]), 64'h000);
`endif

        // Reset mid-frame: outputs drop to zero without a clock edge.
        sample_tick = 1'b1; En = 1'b1;
        for (int i = 0; i < NUM_OPS; i++) begin
            m_inc[i] = m_sh_inc[i];
            m_off[i] = m_sh_off[i];
        end
        @(posedge Clk); #1;
        sample_tick = 1'b1;
        mon_e.op = '0; mon_e.word = m_phase[0] + m_off[0]; mon_e.done = 1'b0;
        sbq.push_back(mon_e);
        @(posedge Clk); #1;
        sample_tick = 1'b0; En = 1'b0;
        @(posedge Clk); #1;
        Reset_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_op_sel", 64'(op_sel), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_addr", 64'(wavetable_addr), 64'd0);
        check("midrst_interp", 64'(interp), 64'd0);
        check("midrst_frame_done", 64'(frame_done), 64'd0);
        check("midrst_overrun", 64'(overrun), 64'd0);
        m_reset();
        @(posedge Clk); #1;
        Reset_n = 1'b1; En = 1'b1;
        run_frame(32'h0, -1, 0, -1, 1'b0, -1);
        check("post_rst_op0", 64'(cap_addr[0]), 64'h000);
        check("post_rst_op3", 64'(cap_addr[3]), 64'h000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
